// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader: FSM states and
// the registered control-output bundle decoded from each state.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = 8;

   typedef struct packed {
      logic byte_ready;
      logic mem_we;
      logic core_rst;
      logic busy;
      logic done;
      logic error;
   } ctrl_t;

   // Moore decode; registered together with the state so outputs switch with it.
   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c          = '0;
      c.core_rst = 1'b1;
      case (s)
         RECV: begin
            c.byte_ready = 1'b1;
            c.busy       = 1'b1;
         end
         WRITE: begin
            c.mem_we = 1'b1;
            c.busy   = 1'b1;
         end
         DONE: begin
            c.core_rst = 1'b0;
            c.done     = 1'b1;
         end
         ERROR: c.error = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word assembler: bytes land in lanes 0..3 as accepted.
// Zero latency on the completion flag; no backpressure of its own.
module byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_clr,
   input  logic                             i_byte_vld,
   input  logic [BYTE_W-1:0]                i_byte_dat,
   output logic [BYTES_PER_WORD*BYTE_W-1:0] o_word,
   output logic                             o_word_complete
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);

   logic [CNT_W-1:0]                 r_byte_cnt;
   logic [BYTES_PER_WORD*BYTE_W-1:0] r_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (i_clr) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (i_byte_vld) begin
         r_word[BYTE_W*r_byte_cnt +: BYTE_W] <= i_byte_dat;
         // Counter wraps to 0 after the last lane, ready for the next word.
         r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
   end

   assign o_word          = r_word;
   assign o_word_complete = i_byte_vld && (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into imem words at 0,4,8,... and holds core reset until done.
// One WRITE cycle after each 4th byte; byte_ready_o drops in WRITE and outside RECV.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int WORD_COUNT = 31,
   parameter int LEN_WIDTH  = $clog2(WORD_COUNT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_data_i,
   output logic                  byte_ready_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_waddr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  core_rst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o
);

   state_t               r_state;
   ctrl_t                r_ctrl;
   logic [LEN_WIDTH-1:0] r_word_cnt;
   logic [LEN_WIDTH-1:0] r_len;

   logic                                 w_xfer;
   logic                                 w_word_complete;
   logic                                 w_len_ok;
   logic                                 w_accept;
   logic [LEN_WIDTH-1:0]                 w_word_cnt_nxt;
   logic [BYTES_PER_WORD*BYTE_W-1:0]     w_word;

   assign w_xfer         = byte_valid_i && r_ctrl.byte_ready;
   assign w_len_ok       = (len_i != '0) && (int'(len_i) <= WORD_COUNT);
   assign w_accept       = start_i && (r_state == IDLE || r_state == DONE || r_state == ERROR);
   assign w_word_cnt_nxt = r_word_cnt + LEN_WIDTH'(1);

   byte_word_packer u_packer (
      .clk             (clk),
      .rst             (rst),
      .i_clr           (w_accept && w_len_ok),
      .i_byte_vld      (w_xfer),
      .i_byte_dat      (byte_data_i),
      .o_word          (w_word),
      .o_word_complete (w_word_complete)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ctrl     <= decode_state(IDLE);
         r_word_cnt <= '0;
         r_len      <= '0;
      end else begin
         case (r_state)
            IDLE, DONE, ERROR: begin
               // start_i outranks any byte offered in the same cycle; no byte is taken here.
               if (start_i) begin
                  if (w_len_ok) begin
                     r_state    <= RECV;
                     r_ctrl     <= decode_state(RECV);
                     r_len      <= len_i;
                     r_word_cnt <= '0;
                  end else begin
                     r_state <= ERROR;
                     r_ctrl  <= decode_state(ERROR);
                  end
               end
            end
            RECV: begin
               if (w_word_complete) begin
                  r_state <= WRITE;
                  r_ctrl  <= decode_state(WRITE);
               end
            end
            WRITE: begin
               r_word_cnt <= w_word_cnt_nxt;
               if (w_word_cnt_nxt == r_len) begin
                  r_state <= DONE;
                  r_ctrl  <= decode_state(DONE);
               end else begin
                  r_state <= RECV;
                  r_ctrl  <= decode_state(RECV);
               end
            end
            default: begin
               r_state <= IDLE;
               r_ctrl  <= decode_state(IDLE);
            end
         endcase
      end
   end

   assign byte_ready_o = r_ctrl.byte_ready;
   assign mem_we_o     = r_ctrl.mem_we;
   assign core_rst_o   = r_ctrl.core_rst;
   assign busy_o       = r_ctrl.busy;
   assign done_o       = r_ctrl.done;
   assign error_o      = r_ctrl.error;

   // The packer is frozen during WRITE (ready low), so address and data stay stable.
   assign mem_waddr_o = ADDR_WIDTH'({r_word_cnt, 2'b00});
   assign mem_wdata_o = DATA_WIDTH'(w_word);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every mem_we_o pulse.
module tb_imem_loader;

   localparam int WC = 31;
   localparam int LW = $clog2(WC + 1);
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic [LW-1:0] len_i = '0;
   logic          byte_valid_i = 1'b0;
   logic [7:0]    byte_data_i = '0;
   logic          byte_ready_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_waddr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          core_rst_o;
   logic          busy_o;
   logic          done_o;
   logic          error_o;

   imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_COUNT(WC)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .len_i        (len_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_waddr_o  (mem_waddr_o),
      .mem_wdata_o  (mem_wdata_o),
      .core_rst_o   (core_rst_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] bq[$];
   int         checks = 0;
   int         errors = 0;
   logic       prev_we = 1'b0;
   wr_t        mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every write must match the oldest expected write and obey the pulse rules.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h required no write at %0t",
                        mem_waddr_o, mem_wdata_o, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", mem_waddr_o, mon_e.addr);
               check("wr_data", mem_wdata_o, mon_e.data);
            end
            check("ready_low_in_write", 32'(byte_ready_o), 32'd0);
            check("we_single_cycle", 32'(prev_we), 32'd0);
            check("core_rst_during_write", 32'(core_rst_o), 32'd1);
         end
         prev_we = mem_we_o;
      end else begin
         prev_we = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic bit len_ok(input int len);
      return (len >= 1) && (len <= WC);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: word i is bytes 4i..4i+3 little-endian, written to byte address 4i.
   task automatic push_expected(input int nwords);
      wr_t e;
      for (int i = 0; i < nwords; i++) begin
         e.addr = 32'(4 * i);
         e.data = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
         exp_q.push_back(e);
      end
   endtask

   task automatic fill_random(input int nbytes);
      bq.delete();
      for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom));
   endtask

   task automatic start_load(input int len);
      start_i = 1'b1;
      len_i   = LW'(len);
      tick();
      start_i = 1'b0;
      len_i   = LW'($urandom);
   endtask

   // gap_mode: 0 valid held high, 1 valid low one cycle between bytes, 2 random gaps.
   task automatic send_bytes(input int count, input int gap_mode);
      for (int i = 0; i < count; i++) begin
         int gap;
         bit got;
         gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < gap; g++) begin
            byte_valid_i = 1'b0;
            byte_data_i  = 8'($urandom);
            tick();
         end
         byte_valid_i = 1'b1;
         byte_data_i  = bq[i];
         got = 1'b0;
         for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (byte_ready_o) got = 1'b1;
            else begin
               @(posedge clk);
               #1;
            end
         end
         if (!got) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got no byte_ready_o required acceptance of byte %0d", i);
            byte_valid_i = 1'b0;
            return;
         end
         tick();
         byte_valid_i = 1'b0;
      end
   endtask

   // Sends all bytes of an accepted load; the cycle after the final WRITE must be DONE.
   task automatic finish_load(input int len, input int gap_mode);
      send_bytes(4 * len, gap_mode);
      check("we_after_last_byte", 32'(mem_we_o), 32'd1);
      tick();
      check("done_after_load", 32'(done_o), 32'd1);
      check("core_rst_released", 32'(core_rst_o), 32'd0);
      check("busy_clear_in_done", 32'(busy_o), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_load(input int len, input int gap_mode);
      push_expected(len);
      start_load(len);
      check("busy_after_start", 32'(busy_o), 32'd1);
      check("core_rst_while_loading", 32'(core_rst_o), 32'd1);
      finish_load(len, gap_mode);
   endtask

   initial begin
      int bad_len;

      // Reset values.
      repeat (2) tick();
      check("rst_ready", 32'(byte_ready_o), 32'd0);
      check("rst_we", 32'(mem_we_o), 32'd0);
      check("rst_waddr", mem_waddr_o, 32'd0);
      check("rst_wdata", mem_wdata_o, 32'd0);
      check("rst_core_rst", 32'(core_rst_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_error", 32'(error_o), 32'd0);
      rst = 1'b0;
      tick();

      // Directed two-word program, valid held high, then with valid toggling.
      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load(2, 0);
      run_load(2, 1);

      // Illegal lengths; stray bytes must not be consumed in ERROR.
      start_load(0);
      check("err_len0", 32'(error_o), 32'd1);
      check("err_core_rst", 32'(core_rst_o), 32'd1);
      check("err_busy", 32'(busy_o), 32'd0);
      byte_valid_i = 1'b1;
      byte_data_i  = 8'hA5;
      repeat (3) begin
         tick();
         check("err_ready_low", 32'(byte_ready_o), 32'd0);
      end
      byte_valid_i = 1'b0;
      bad_len = (WC + 1) % (1 << LW);
      start_load(WC + 1);
      check("err_len_over", 32'(error_o), 32'(!len_ok(bad_len)));
      fill_random(4);
      run_load(1, 0);

      // Full-depth load with an incrementing pattern.
      bq.delete();
      for (int k = 0; k < 4 * WC; k++) bq.push_back(8'(k));
      run_load(WC, 0);

      // Reset mid-load after six bytes of a three-word load: only word 0 lands.
      fill_random(12);
      push_expected(1);
      start_load(3);
      send_bytes(6, 0);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_core_rst", 32'(core_rst_o), 32'd1);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_ready", 32'(byte_ready_o), 32'd0);
      check("midrst_queue", 32'(exp_q.size()), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      fill_random(12);
      run_load(3, 2);

      // start_i together with a byte in DONE: start wins, byte is dropped.
      fill_random(4);
      push_expected(1);
      start_i      = 1'b1;
      len_i        = LW'(1);
      byte_valid_i = 1'b1;
      byte_data_i  = 8'hEE;
      tick();
      start_i      = 1'b0;
      byte_valid_i = 1'b0;
      check("done_restart_core_rst", 32'(core_rst_o), 32'd1);
      check("done_restart_busy", 32'(busy_o), 32'd1);
      check("done_restart_done", 32'(done_o), 32'd0);
      finish_load(1, 0);

      // Randomized loads with random gaps.
      for (int n = 0; n < 8; n++) begin
         int len;
         len = int'($urandom_range(1, 8));
         fill_random(4 * len);
         run_load(len, 2);
      end

      repeat (3) tick();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
